// File: rtl/hazard_ctrl_pkg.sv
// Shared types and helpers for the LEGv8 hazard sequencer.
// Holds the FSM state encoding, forwarding-select codes and the register-match test.
package hazard_pkg;

    localparam int REG_W = 5;
    localparam logic [REG_W-1:0] ZERO_REG = 5'd31;

    typedef logic [REG_W-1:0] reg_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam logic [1:0] FWD_REG   = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

    // XZR never creates a dependency, whichever side it appears on.
    function automatic logic reg_match(input logic use_x, input reg_t x, input reg_t r,
                                       input reg_t zero);
        return use_x && (r != zero) && (x == r);
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side signal bundle for hazard_ctrl.
// master = pipeline (drives specifiers/control), slave = hazard sequencer.
interface hazard_ctrl_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 32
);
    logic [REG_W-1:0] ifid_rn, ifid_rm;
    logic             ifid_use_rn, ifid_use_rm;
    logic [REG_W-1:0] idex_rn, idex_rm, idex_rd;
    logic             idex_regwrite, idex_memread;
    logic [REG_W-1:0] exmem_rd;
    logic             exmem_regwrite;
    logic [REG_W-1:0] memwb_rd;
    logic             memwb_regwrite;
    logic             exmem_take_branch;

    logic             pc_write, ifid_write, idex_bubble;
    logic             ifid_flush, idex_flush, exmem_flush;
    logic [1:0]       fwd_a, fwd_b;
    logic [CNT_W-1:0] stall_cycles, flush_events;
    logic             stall_timeout;

    modport master (
        output ifid_rn, ifid_rm, ifid_use_rn, ifid_use_rm,
               idex_rn, idex_rm, idex_rd, idex_regwrite, idex_memread,
               exmem_rd, exmem_regwrite, memwb_rd, memwb_regwrite, exmem_take_branch,
        input  pc_write, ifid_write, idex_bubble, ifid_flush, idex_flush, exmem_flush,
               fwd_a, fwd_b, stall_cycles, flush_events, stall_timeout
    );

    modport slave (
        input  ifid_rn, ifid_rm, ifid_use_rn, ifid_use_rm,
               idex_rn, idex_rm, idex_rd, idex_regwrite, idex_memread,
               exmem_rd, exmem_regwrite, memwb_rd, memwb_regwrite, exmem_take_branch,
        output pc_write, ifid_write, idex_bubble, ifid_flush, idex_flush, exmem_flush,
               fwd_a, fwd_b, stall_cycles, flush_events, stall_timeout
    );
endinterface

// File: rtl/hazard_ctrl_fwd_unit.sv
// EX-stage forwarding selects; EX/MEM result takes precedence over MEM/WB data.
module fwd_unit
    import hazard_pkg::*;
#(
    parameter int REG_W    = 5,
    parameter int ZERO_REG = 31
) (
    input  logic [REG_W-1:0] idex_rn,
    input  logic [REG_W-1:0] idex_rm,
    input  logic [REG_W-1:0] exmem_rd,
    input  logic             exmem_regwrite,
    input  logic [REG_W-1:0] memwb_rd,
    input  logic             memwb_regwrite,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b
);
    localparam reg_t ZR = reg_t'(ZERO_REG);

    always_comb begin
        fwd_a = FWD_REG;
        fwd_b = FWD_REG;
        if (reg_match(exmem_regwrite, idex_rn, exmem_rd, ZR))
            fwd_a = FWD_EXMEM;
        else if (reg_match(memwb_regwrite, idex_rn, memwb_rd, ZR))
            fwd_a = FWD_MEMWB;
        if (reg_match(exmem_regwrite, idex_rm, exmem_rd, ZR))
            fwd_b = FWD_EXMEM;
        else if (reg_match(memwb_regwrite, idex_rm, memwb_rd, ZR))
            fwd_b = FWD_MEMWB;
    end
endmodule

// File: rtl/hazard_ctrl.sv
// Hazard sequencer for the 5-stage LEGv8 pipeline: stalls, branch flushes, forwarding, perf counters.
// Define HAZARD_CTRL_FWD_EN for forwarding (load-use stalls only); otherwise full RAW stalls.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_W     = 5,
    parameter int ZERO_REG  = 31,
    parameter int CNT_W     = 32,
    parameter int MAX_STALL = 4
) (
    input logic        clk,
    input logic        reset,
    hazard_ctrl_if.slave hz
);
    localparam reg_t ZR = reg_t'(ZERO_REG);
    localparam int SC_W = $clog2(MAX_STALL + 1);
    localparam logic [SC_W-1:0] SC_MAX  = SC_W'(MAX_STALL);
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(MAX_STALL - 1);

    state_t          state;
    logic [SC_W-1:0] stall_cnt;
    logic            hazard_src, branch, stall;
    logic [1:0]      fa_raw, fb_raw;

    always_comb begin
`ifdef HAZARD_CTRL_FWD_EN
        hazard_src = hz.idex_memread && hz.idex_regwrite &&
                     (reg_match(hz.ifid_use_rn, hz.ifid_rn, hz.idex_rd, ZR) ||
                      reg_match(hz.ifid_use_rm, hz.ifid_rm, hz.idex_rd, ZR));
`else
        hazard_src =
            (hz.idex_regwrite  && (reg_match(hz.ifid_use_rn, hz.ifid_rn, hz.idex_rd, ZR) ||
                                   reg_match(hz.ifid_use_rm, hz.ifid_rm, hz.idex_rd, ZR))) ||
            (hz.exmem_regwrite && (reg_match(hz.ifid_use_rn, hz.ifid_rn, hz.exmem_rd, ZR) ||
                                   reg_match(hz.ifid_use_rm, hz.ifid_rm, hz.exmem_rd, ZR))) ||
            (hz.memwb_regwrite && (reg_match(hz.ifid_use_rn, hz.ifid_rn, hz.memwb_rd, ZR) ||
                                   reg_match(hz.ifid_use_rm, hz.ifid_rm, hz.memwb_rd, ZR)));
`endif
        // Reset forces idle; FLUSH means the older stages hold bubbles, so no hazard is real.
        branch = reset && hz.exmem_take_branch;
        stall  = reset && (state != FLUSH) && hazard_src && !branch;
    end

`ifdef HAZARD_CTRL_FWD_EN
    fwd_unit #(.REG_W(REG_W), .ZERO_REG(ZERO_REG)) u_fwd (
        .idex_rn        (hz.idex_rn),
        .idex_rm        (hz.idex_rm),
        .exmem_rd       (hz.exmem_rd),
        .exmem_regwrite (hz.exmem_regwrite),
        .memwb_rd       (hz.memwb_rd),
        .memwb_regwrite (hz.memwb_regwrite),
        .fwd_a          (fa_raw),
        .fwd_b          (fb_raw)
    );
`else
    assign fa_raw = FWD_REG;
    assign fb_raw = FWD_REG;
`endif

    assign hz.pc_write    = !stall;
    assign hz.ifid_write  = !stall;
    assign hz.idex_bubble = stall;
    assign hz.ifid_flush  = branch;
    assign hz.idex_flush  = branch;
    assign hz.exmem_flush = branch;
    assign hz.fwd_a       = reset ? fa_raw : FWD_REG;
    assign hz.fwd_b       = reset ? fb_raw : FWD_REG;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state            <= RUN;
            stall_cnt        <= '0;
            hz.stall_cycles  <= '0;
            hz.flush_events  <= '0;
            hz.stall_timeout <= 1'b0;
        end else begin
            if (branch)
                state <= FLUSH;
            else if (stall)
                state <= STALL;
            else
                state <= RUN;

            if (stall && (hz.stall_cycles != '1))
                hz.stall_cycles <= hz.stall_cycles + CNT_W'(1);
            if (branch && (hz.flush_events != '1))
                hz.flush_events <= hz.flush_events + CNT_W'(1);

            // Run length saturates at MAX_STALL; the flag is set as the run reaches it.
            if (!stall)
                stall_cnt <= '0;
            else if (stall_cnt != SC_MAX)
                stall_cnt <= stall_cnt + SC_W'(1);
            if (stall && (stall_cnt == SC_LAST))
                hz.stall_timeout <= 1'b1;
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl (MAX_STALL=2); honours HAZARD_CTRL_FWD_EN if defined.
module tb_hazard_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    hazard_ctrl_if bus ();

    hazard_ctrl #(.MAX_STALL(2)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (bus)
    );

    typedef struct {
        int unsigned rn, rm, urn, urm;
        int unsigned xrn, xrm, xrd, xrw, xmr;
        int unsigned mrd, mrw, wrd, wrw;
        int unsigned st_f, st_n, fa, fb;
        string       name;
    } vec_t;

    vec_t vecs[12];

`ifdef HAZARD_CTRL_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [9:0] exp_ctl(input logic st, input logic br,
                                           input logic [1:0] fa, input logic [1:0] fb);
        return {~st, ~st, st, br, br, br, fa, fb};
    endfunction

    function automatic logic [9:0] ctl();
        return {bus.pc_write, bus.ifid_write, bus.idex_bubble, bus.ifid_flush,
                bus.idex_flush, bus.exmem_flush, bus.fwd_a, bus.fwd_b};
    endfunction

    task automatic clear_in();
        bus.ifid_rn = '0;        bus.ifid_rm = '0;
        bus.ifid_use_rn = 1'b0;  bus.ifid_use_rm = 1'b0;
        bus.idex_rn = '0;        bus.idex_rm = '0;        bus.idex_rd = '0;
        bus.idex_regwrite = 1'b0; bus.idex_memread = 1'b0;
        bus.exmem_rd = '0;       bus.exmem_regwrite = 1'b0;
        bus.memwb_rd = '0;       bus.memwb_regwrite = 1'b0;
        bus.exmem_take_branch = 1'b0;
    endtask

    // LDUR X2 in EX, ID instruction reads X2 as rn: stalls in both builds.
    task automatic load_use();
        clear_in();
        bus.ifid_rn = 5'd2; bus.ifid_use_rn = 1'b1;
        bus.idex_rd = 5'd2; bus.idex_regwrite = 1'b1; bus.idex_memread = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk); reset = 1'b0; clear_in();
        @(negedge clk); reset = 1'b1;
    endtask

    initial begin
        vecs[0]  = '{0, 0, 0, 0,   0, 0, 0, 0, 0,    0, 0, 0, 0,    0, 0, 0, 0, "idle"};
        vecs[1]  = '{2, 6, 1, 1,   5, 6, 2, 1, 1,    7, 0, 8, 0,    1, 1, 0, 0, "lu_rn"};
        vecs[2]  = '{1, 9, 0, 1,   0, 0, 9, 1, 1,    0, 0, 0, 0,    1, 1, 0, 0, "lu_rm"};
        vecs[3]  = '{1, 9, 1, 0,   0, 0, 9, 1, 1,    0, 0, 0, 0,    0, 0, 0, 0, "lu_rm_unused"};
        vecs[4]  = '{31, 0, 1, 0,  31, 0, 31, 1, 1,  31, 1, 0, 0,   0, 0, 0, 0, "lu_xzr"};
        vecs[5]  = '{4, 0, 1, 0,   0, 0, 4, 1, 0,    0, 0, 0, 0,    0, 1, 0, 0, "raw_ex"};
        vecs[6]  = '{3, 0, 1, 0,   3, 0, 0, 0, 0,    3, 1, 3, 1,    0, 1, 2, 0, "fwd_a_exmem"};
        vecs[7]  = '{3, 0, 1, 0,   3, 0, 0, 0, 0,    3, 0, 3, 1,    0, 1, 1, 0, "fwd_a_memwb"};
        vecs[8]  = '{0, 12, 0, 1,  0, 12, 0, 0, 0,   0, 0, 12, 1,   0, 1, 0, 1, "fwd_b_memwb"};
        vecs[9]  = '{31, 0, 1, 0,  31, 0, 0, 0, 0,   31, 1, 0, 0,   0, 0, 0, 0, "xzr_exmem"};
        vecs[10] = '{5, 0, 1, 0,   0, 0, 5, 0, 1,    0, 0, 0, 0,    0, 0, 0, 0, "load_no_rw"};
        vecs[11] = '{0, 0, 0, 0,   0, 6, 0, 0, 0,    6, 1, 6, 1,    0, 0, 0, 2, "fwd_b_exmem"};

        // Under reset every control output is idle, even with hazard and branch inputs present.
        clear_in();
        load_use();
        bus.exmem_take_branch = 1'b1;
        @(negedge clk); #1;
        check("reset_ctl", ctl(), exp_ctl(1'b0, 1'b0, 2'b00, 2'b00));
        check("reset_stall_cycles", bus.stall_cycles, 0);
        check("reset_flush_events", bus.flush_events, 0);
        check("reset_timeout", bus.stall_timeout, 0);
        do_reset();

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            clear_in();
            bus.ifid_rn = 5'(vecs[i].rn);          bus.ifid_rm = 5'(vecs[i].rm);
            bus.ifid_use_rn = 1'(vecs[i].urn);     bus.ifid_use_rm = 1'(vecs[i].urm);
            bus.idex_rn = 5'(vecs[i].xrn);         bus.idex_rm = 5'(vecs[i].xrm);
            bus.idex_rd = 5'(vecs[i].xrd);
            bus.idex_regwrite = 1'(vecs[i].xrw);   bus.idex_memread = 1'(vecs[i].xmr);
            bus.exmem_rd = 5'(vecs[i].mrd);        bus.exmem_regwrite = 1'(vecs[i].mrw);
            bus.memwb_rd = 5'(vecs[i].wrd);        bus.memwb_regwrite = 1'(vecs[i].wrw);
            #1;
            if (FWD)
                check(vecs[i].name, ctl(), exp_ctl(1'(vecs[i].st_f), 1'b0,
                                                   2'(vecs[i].fa), 2'(vecs[i].fb)));
            else
                check(vecs[i].name, ctl(), exp_ctl(1'(vecs[i].st_n), 1'b0, 2'b00, 2'b00));
        end

        // Load-use: one stall, then the load sits in EX/MEM (which still stalls without forwarding).
        do_reset();
        @(negedge clk); load_use(); #1;
        check("lu_seq_stall", ctl(), exp_ctl(1'b1, 1'b0, 2'b00, 2'b00));
        @(negedge clk);
        clear_in();
        bus.ifid_rn = 5'd2; bus.ifid_use_rn = 1'b1;
        bus.exmem_rd = 5'd2; bus.exmem_regwrite = 1'b1;
        #1;
        check("lu_seq_release", ctl(), exp_ctl(!FWD, 1'b0, 2'b00, 2'b00));
        check("lu_seq_stall_cycles", bus.stall_cycles, 1);
        @(negedge clk); clear_in(); #1;
        check("lu_seq_idle", ctl(), exp_ctl(1'b0, 1'b0, 2'b00, 2'b00));

        // Two isolated single-cycle stalls never accumulate to the watchdog limit.
        do_reset();
        @(negedge clk); load_use();
        @(negedge clk); clear_in();
        @(negedge clk); load_use();
        @(negedge clk); clear_in(); #1;
        check("wd_isolated_timeout", bus.stall_timeout, 0);
        check("wd_isolated_count", bus.stall_cycles, 2);

        // Three back-to-back stalls: watchdog trips after the second, sticky until reset.
        do_reset();
        @(negedge clk);
        clear_in();
        bus.ifid_rn = 5'd4; bus.ifid_use_rn = 1'b1;
        if (FWD) load_use_hold4();
        else begin bus.idex_rd = 5'd4; bus.idex_regwrite = 1'b1; end
        #1;
        check("raw3_c1", ctl(), exp_ctl(1'b1, 1'b0, 2'b00, 2'b00));
        @(negedge clk);
        if (!FWD) begin
            bus.idex_rd = '0; bus.idex_regwrite = 1'b0;
            bus.exmem_rd = 5'd4; bus.exmem_regwrite = 1'b1;
        end
        #1;
        check("raw3_c2", ctl(), exp_ctl(1'b1, 1'b0, 2'b00, 2'b00));
        check("raw3_timeout_c2", bus.stall_timeout, 0);
        @(negedge clk);
        if (!FWD) begin
            bus.exmem_rd = '0; bus.exmem_regwrite = 1'b0;
            bus.memwb_rd = 5'd4; bus.memwb_regwrite = 1'b1;
        end
        #1;
        check("raw3_c3", ctl(), exp_ctl(1'b1, 1'b0, 2'b00, 2'b00));
        check("raw3_timeout_c3", bus.stall_timeout, 1);
        @(negedge clk);
        clear_in();
        bus.ifid_rn = 5'd4; bus.ifid_use_rn = 1'b1;
        #1;
        check("raw3_release", ctl(), exp_ctl(1'b0, 1'b0, 2'b00, 2'b00));
        check("raw3_stall_cycles", bus.stall_cycles, 3);
        @(negedge clk); clear_in(); #1;
        check("raw3_timeout_sticky", bus.stall_timeout, 1);
        @(negedge clk); reset = 1'b0;
        @(negedge clk); reset = 1'b1; #1;
        check("post_reset_timeout", bus.stall_timeout, 0);
        check("post_reset_stall_cycles", bus.stall_cycles, 0);
        check("post_reset_ctl", ctl(), exp_ctl(1'b0, 1'b0, 2'b00, 2'b00));

        // Branch taken during a load-use stall, then one FLUSH cycle with detection suppressed.
        do_reset();
        @(negedge clk); load_use(); #1;
        check("br_pre_stall", ctl(), exp_ctl(1'b1, 1'b0, 2'b00, 2'b00));
        @(negedge clk); bus.exmem_take_branch = 1'b1; #1;
        check("br_flush_ctl", ctl(), exp_ctl(1'b0, 1'b1, 2'b00, 2'b00));
        @(negedge clk); bus.exmem_take_branch = 1'b0; #1;
        check("br_flush_state_idle", ctl(), exp_ctl(1'b0, 1'b0, 2'b00, 2'b00));
        check("br_flush_events", bus.flush_events, 1);
        check("br_stall_cycles", bus.stall_cycles, 1);
        @(negedge clk); #1;
        check("br_back_to_run", ctl(), exp_ctl(1'b1, 1'b0, 2'b00, 2'b00));
        @(negedge clk); bus.exmem_take_branch = 1'b1; #1;
        check("br_in_stall_again", ctl(), exp_ctl(1'b0, 1'b1, 2'b00, 2'b00));
        @(negedge clk); #1;
        check("br_in_flush", ctl(), exp_ctl(1'b0, 1'b1, 2'b00, 2'b00));
        @(negedge clk); clear_in(); #1;
        check("br_flush_events_3", bus.flush_events, 3);

        // Reset asserted mid-stall.
        do_reset();
        @(negedge clk); load_use(); #1;
        check("rst_mid_stall", ctl(), exp_ctl(1'b1, 1'b0, 2'b00, 2'b00));
        @(negedge clk); reset = 1'b0; #1;
        check("rst_mid_idle", ctl(), exp_ctl(1'b0, 1'b0, 2'b00, 2'b00));
        @(negedge clk); reset = 1'b1; #1;
        check("rst_mid_counters", bus.stall_cycles, 0);
        check("rst_mid_run_stall", ctl(), exp_ctl(1'b1, 1'b0, 2'b00, 2'b00));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // With forwarding, a load into X4 held in EX keeps the ID reader stalled.
    task automatic load_use_hold4();
        bus.idex_rd = 5'd4; bus.idex_regwrite = 1'b1; bus.idex_memread = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
endmodule
